mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit placed between the EX/MEM pipeline register and the byte-addressed data SRAM, which reads combinationally and writes on posedge.
- Decodes load, store and atomic-swap ops into SRAM byte-enable, address and write-data signals.
- Sign- or zero-extends load data and registers the result into the MEM/WB register.
- Sequences a two-cycle AMOSWAP.W as read-old then write-new.

Parameters:
- ADDR_W, 16, SRAM byte-address width; only the low ADDR_W bits of in_addr are used.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  unit accepts the instruction this cycle
- in_mem_read  in  1  load op
- in_mem_write  in  1  store op
- in_mem_amo  in  1  AMOSWAP.W op
- in_funct3  in  3  access size and sign
- in_addr  in  32  effective address; also the ALU result
- in_store_data  in  32  rs2 value
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- stall  in  1  downstream hazard; freeze the unit
- sram_w_en  out  4  byte write mask
- sram_address  out  ADDR_W  byte address
- sram_write_data  out  32  write data
- sram_read_data  in  32  combinational read data
- wb_valid  out  1  MEM/WB entry is valid
- wb_rd  out  5  destination register
- wb_reg_write  out  1  write-back enable
- wb_data  out  32  load result or ALU result
- wb_misaligned  out  1  misaligned-access flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: state=IDLE; wb_valid, wb_rd, wb_reg_write, wb_data and wb_misaligned all 0. Combinational outputs give sram_w_en=0000 during reset.
- States are IDLE and AMO_WR.
- in_ready = (state==IDLE) && !stall. Accept means in_valid && in_ready.
- sram_address = in_addr[ADDR_W-1:0] in IDLE, or the latched AMO address in AMO_WR. The SRAM's address+1..+3 wrap is accepted; no check is made.
- Store byte enables, asserted only in the accept cycle:
  - funct3 000 SB: w_en=0001
  - funct3 001 SH: w_en=0011
  - funct3 010 SW: w_en=1111
  - other funct3: w_en=0000
- sram_write_data = in_store_data, unshifted, because the SRAM places byte0 at address. Mask 0111 is never generated.
- sram_w_en=0000 in every other case: not accepted, stall, reset, load, non-memory op.
- Load extension of sram_read_data, captured at the accept edge:
  - 000 LB: sign-extend [7:0]
  - 001 LH: sign-extend [15:0]
  - 010 LW: full word
  - 100 LBU: zero-extend [7:0]
  - 101 LHU: zero-extend [15:0]
  - other funct3: full word
- Non-memory op: wb_data = in_addr.
- Latency: load, store and ALU ops go accept → MEM/WB valid at the next edge (1 cycle). Stores give wb_reg_write=0.
- AMOSWAP.W (in_mem_amo, word):
  - Accept cycle: w_en=0000. Latch address, store data and rd; latch the old word into wb_data. wb_valid stays 0. Go to AMO_WR.
  - AMO_WR with !stall: drive w_en=1111 with the latched data. At the edge set wb_valid=1 with the old word, then return to IDLE.
  - AMO_WR with stall=1: w_en=0000 and the state holds.
  - Total 2 cycles.
- stall=1 in IDLE: all wb_* registers hold their values and nothing is accepted.
- !stall and no accept: wb_valid becomes 0 at the next edge.
- Simultaneous flags: priority is amo > write > read.
- Reset during AMO_WR: the write is dropped and the state returns to IDLE.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW/AMO with addr[1:0]!=00.
  - Response: w_en forced to 0000 and the AMO is not started. MEM/WB receives wb_misaligned=1, wb_reg_write=0 and wb_data=in_addr, with 1-cycle latency.
- MEM_ALIGN_CHECK_EN not defined:
  - Unaligned accesses proceed byte-wise.
  - wb_misaligned is tied to 0.

Test Plan:
1. SW addr 0x0100, data 0xDEADBEEF; then LW 0x0100 → w_en=1111 in one cycle; next cycle wb_data=0xDEADBEEF, wb_valid=1.
2. Bytes 0x80,0x7F at 0x0200: LB → 0xFFFFFF80; LBU → 0x00000080; LH → 0x00007F80.
3. SB 0x0300 data 0x12345678 over existing 0xAABBCCDD → w_en=0001; LW reads 0xAABBCC78.
4. AMO at 0x0400 (old 0x11111111), new 0x22222222 → in_ready=0 for 1 cycle; second cycle w_en=1111; wb_data=0x11111111; LW then reads 0x22222222.
5. stall=1 for 3 cycles during AMO_WR → w_en=0000 and wb registers hold; after release the write completes. rst asserted during AMO_WR → no write, wb_valid=0.
6. With MEM_ALIGN_CHECK_EN: SW at 0x0102 → w_en=0000, wb_misaligned=1, wb_data=0x00000102.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data SRAM, extends load data into MEM/WB and runs AMOSWAP.W as a two-cycle read-then-write.
// Optional build macro MEM_ALIGN_CHECK_EN traps misaligned halfword/word/AMO accesses instead of letting them go byte-wise.
module mem_stage_lsu #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_amo,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              stall,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              wb_misaligned
);

  typedef enum logic [0:0] {IDLE = 1'b0, AMO_WR = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  amo_addr_q, amo_addr_d;
  logic [31:0]        amo_data_q, amo_data_d;
  logic [4:0]         amo_rd_q, amo_rd_d;
  logic               amo_rw_q, amo_rw_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               wb_reg_write_q, wb_reg_write_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               wb_misaligned_q, wb_misaligned_d;

  logic accept_s;
  logic is_amo_s;
  logic is_wr_s;
  logic is_rd_s;
  logic misaligned_s;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  load_ext = {24'h000000, d[7:0]};
      3'b101:  load_ext = {16'h0000, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Operation decode with amo > write > read priority, plus optional alignment trap
  always_comb begin
    is_amo_s = in_mem_amo;
    is_wr_s  = !in_mem_amo && in_mem_write;
    is_rd_s  = !in_mem_amo && !in_mem_write && in_mem_read;
    in_ready = (state_q == IDLE) && !stall;
    accept_s = in_valid && in_ready && !rst;
`ifdef MEM_ALIGN_CHECK_EN
    if (is_amo_s) begin
      misaligned_s = (in_addr[1:0] != 2'b00);
    end else if (is_wr_s || is_rd_s) begin
      case (in_funct3)
        3'b001, 3'b101: misaligned_s = in_addr[0];
        3'b010:         misaligned_s = (in_addr[1:0] != 2'b00);
        default:        misaligned_s = 1'b0;
      endcase
    end else begin
      misaligned_s = 1'b0;
    end
`else
    misaligned_s = 1'b0;
`endif
  end

  // SRAM request: store mask in the accept cycle, AMO write-back in AMO_WR
  always_comb begin
    sram_w_en       = 4'b0000;
    sram_address    = in_addr[ADDR_W-1:0];
    sram_write_data = in_store_data;
    if (state_q == AMO_WR) begin
      sram_address    = amo_addr_q;
      sram_write_data = amo_data_q;
      if (!stall && !rst) begin
        sram_w_en = 4'b1111;
      end else begin
        sram_w_en = 4'b0000;
      end
    end else if (accept_s && is_wr_s && !misaligned_s) begin
      case (in_funct3)
        3'b000:  sram_w_en = 4'b0001;
        3'b001:  sram_w_en = 4'b0011;
        3'b010:  sram_w_en = 4'b1111;
        default: sram_w_en = 4'b0000;
      endcase
    end else begin
      sram_w_en = 4'b0000;
    end
  end

  // Next-state and MEM/WB update
  always_comb begin
    state_d         = state_q;
    amo_addr_d      = amo_addr_q;
    amo_data_d      = amo_data_q;
    amo_rd_d        = amo_rd_q;
    amo_rw_d        = amo_rw_q;
    wb_valid_d      = wb_valid_q;
    wb_rd_d         = wb_rd_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_data_d       = wb_data_q;
    wb_misaligned_d = wb_misaligned_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = IDLE;
        end else if (!accept_s) begin
          wb_valid_d = 1'b0;
        end else if (misaligned_s) begin
          wb_valid_d      = 1'b1;
          wb_rd_d         = in_rd;
          wb_reg_write_d  = 1'b0;
          wb_data_d       = in_addr;
          wb_misaligned_d = 1'b1;
        end else if (is_amo_s) begin
          // Old word goes to wb_data now; wb_valid waits for the write cycle
          wb_valid_d      = 1'b0;
          wb_data_d       = sram_read_data;
          wb_misaligned_d = 1'b0;
          amo_addr_d      = in_addr[ADDR_W-1:0];
          amo_data_d      = in_store_data;
          amo_rd_d        = in_rd;
          amo_rw_d        = in_reg_write;
          state_d         = AMO_WR;
        end else begin
          wb_valid_d      = 1'b1;
          wb_rd_d         = in_rd;
          wb_misaligned_d = 1'b0;
          if (is_wr_s) begin
            wb_reg_write_d = 1'b0;
            wb_data_d      = in_addr;
          end else if (is_rd_s) begin
            wb_reg_write_d = in_reg_write;
            wb_data_d      = load_ext(in_funct3, sram_read_data);
          end else begin
            wb_reg_write_d = in_reg_write;
            wb_data_d      = in_addr;
          end
        end
      end
      AMO_WR: begin
        if (!stall) begin
          wb_valid_d     = 1'b1;
          wb_rd_d        = amo_rd_q;
          wb_reg_write_d = amo_rw_q;
          state_d        = IDLE;
        end else begin
          state_d = AMO_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and MEM/WB registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      amo_addr_q      <= {ADDR_W{1'b0}};
      amo_data_q      <= 32'h0000_0000;
      amo_rd_q        <= 5'd0;
      amo_rw_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_reg_write_q  <= 1'b0;
      wb_data_q       <= 32'h0000_0000;
      wb_misaligned_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      amo_addr_q      <= amo_addr_d;
      amo_data_q      <= amo_data_d;
      amo_rd_q        <= amo_rd_d;
      amo_rw_q        <= amo_rw_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_data_q       <= wb_data_d;
      wb_misaligned_q <= wb_misaligned_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule
